tile_burst_rr_arbiter: RTL and testbench
========================================

Name: tile_burst_rr_arbiter

Overview:
- Round-robin arbiter with burst locking. It shares one valid/ready flit or beat channel (e.g. the NI narrow/wide request path of a compute tile) between NumReq requesters.
- A grant is held from the first presented beat until the beat carrying last is accepted. Bursts are never interleaved, and the output is stable while stalled.
- Sits between tile-local masters (cluster, DMA, debug/config master) and the single NI slave port of floo_noc_pd_top.
- Provides a burst-length watchdog and a grant-index output so the downstream can route responses back.

Parameters:
- NumReq, 3, number of requesters (>=2).
- DataWidth, 64, payload width per requester in bits.
- MaxBurstBeats, 256, beats in a burst before the watchdog error fires (>=1).
- IdxW, max(1,$clog2(NumReq)), derived; width of the index signals.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NumReq  per-requester beat valid.
- req_ready_o  out  NumReq  per-requester beat ready.
- req_data_i  in  NumReq*DataWidth  payloads; requester i occupies bits [i*DataWidth +: DataWidth].
- req_last_i  in  NumReq  last beat of burst, per requester.
- enable_i  in  NumReq  requester enable mask; sampled only when a new grant is chosen.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  output beat ready.
- out_data_o  out  DataWidth  granted payload.
- out_last_o  out  1  granted last.
- out_idx_o  out  IdxW  index of the granted requester.
- busy_o  out  1  high while in LOCKED.
- err_o  out  1  sticky watchdog error.

Behaviour:
- Handshake: a beat transfers when out_valid_o && out_ready_i. The transfer is the same cycle for the granted requester; there is no pipeline register and the added latency is 0 cycles.
- Non-granted requesters always see req_ready_o = 0.
- req_ready_o[g] = out_ready_i for the granted index g.
- Output is combinational from the selected requester: data, last, valid. out_idx_o = g.
- When no requester is selected: out_valid_o = 0, out_data_o = 0, out_last_o = 0, out_idx_o = rr_ptr.
- State registers: state {IDLE, LOCKED}, lock_idx (IdxW), rr_ptr (IdxW), beat_cnt ($clog2(MaxBurstBeats+1) bits), err (1).
- Reset values: state=IDLE, lock_idx=0, rr_ptr=0, beat_cnt=0, err=0.
- Outputs after reset: out_valid_o=0, req_ready_o=0, busy_o=0, err_o=0.
- IDLE selection:
  - Candidates are requesters with req_valid_i[i] && enable_i[i].
  - g = first candidate at or after rr_ptr, searching upward with wrap from NumReq-1 to 0.
  - If there are no candidates, there is no selection.
- IDLE transitions:
  - Selection present, handshake, and out_last_o: stay in IDLE; rr_ptr <= (g+1) mod NumReq; beat_cnt <= 0.
  - Selection present and either no handshake, or a handshake without last: go to LOCKED; lock_idx <= g.
  - In the handshake-without-last case, beat_cnt <= 1.
  - Entering LOCKED on a stall keeps the selection stable. Valid and data must not change while out_ready_i is low.
- LOCKED:
  - g = lock_idx. enable_i and the other requesters are ignored.
  - out_valid_o = req_valid_i[lock_idx]. A requester dropping valid mid-burst is permitted and simply stalls the channel.
  - On handshake with last: go to IDLE; rr_ptr <= (lock_idx+1) mod NumReq; beat_cnt <= 0.
  - On handshake without last: beat_cnt increments, saturating at MaxBurstBeats.
- busy_o = (state == LOCKED).
- Watchdog:
  - When a non-last beat is accepted with beat_cnt == MaxBurstBeats-1, err <= 1 on the next edge. That beat is the MaxBurstBeats-th with no last.
  - err is sticky until reset. The burst is not broken; the lock is held.
  - err_o = err.
- Fairness: a requester that stays valid and enabled is granted within NumReq-1 bursts by other requesters.
- Pointer wrap: with lock_idx = NumReq-1, the next rr_ptr is 0.
- Simultaneous events:
  - A new request arriving in the same cycle as a last handshake is not granted that cycle. Arbitration resumes next cycle from the updated rr_ptr.
  - A back-to-back single-beat grant to a different requester is possible every cycle.
- Reset mid-burst: all state clears asynchronously. The partial burst is abandoned and the upstream/downstream are reset together.
- Assertions (simulation only):
  - At most one req_ready_o is high at a time.
  - Output valid, data, last and idx are stable while out_valid_o && !out_ready_i.

Test Plan:
1. NumReq=3, all requesters valid with single-beat last bursts, out_ready_i=1 → grant order 0,1,2,0,1,2 with one beat per cycle; rr_ptr wraps 2→0.
2. Req0 sends a 4-beat burst and req1 asserts valid at beat 2 → out_idx_o=0 for all 4 beats and req_ready_o[1]=0 throughout. Req1 is granted the cycle after req0's last.
3. Req2 valid, out_ready_i=0 for 5 cycles, then req0 asserts valid at cycle 2 → state LOCKED, out_idx_o stays 2, and out_data_o is stable until out_ready_i rises.
4. enable_i=3'b101 with all requesters valid → req1 is never granted. Clearing enable_i[0] mid-burst of req0 does not break the burst.
5. MaxBurstBeats=4, req0 sends 6 beats with last on beat 6 → err_o rises the cycle after beat 4 is accepted and stays 1 after the burst ends; the grant is released after beat 6.
6. Reset asserted while LOCKED with beat_cnt=3 → immediately out_valid_o=0, busy_o=0, err_o=0; after release the first grant goes to the lowest valid index from rr_ptr=0.

Source files
------------

// File: rtl/tile_burst_rr_arbiter.sv
// Round-robin arbiter with burst locking onto one valid/ready channel; 0-cycle latency.
// Backpressure: out_ready_i passes straight through to the granted requester only.
module tile_burst_rr_arbiter #(
  parameter int unsigned NumReq        = 3,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned MaxBurstBeats = 256,
  localparam int unsigned IdxW         = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  input  logic [NumReq-1:0]             req_last_i,
  input  logic [NumReq-1:0]             enable_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DataWidth-1:0]          out_data_o,
  output logic                          out_last_o,
  output logic [IdxW-1:0]               out_idx_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int unsigned CntW = $clog2(MaxBurstBeats + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e              state;
  logic [IdxW-1:0]     lock_idx;
  logic [IdxW-1:0]     rr_ptr;
  logic [CntW-1:0]     beat_cnt;
  logic                err;

  logic                sel_vld;
  logic [IdxW-1:0]     sel_idx;
  logic [2*NumReq-1:0] cand2;
  logic [IdxW:0]       sum;
  logic                hs;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] v);
    return (v == IdxW'(NumReq - 1)) ? '0 : v + IdxW'(1);
  endfunction

  // Rotating the doubled candidate vector by rr_ptr puts the search start at bit 0.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = rr_ptr;
    sum     = '0;
    cand2   = {req_valid_i & enable_i, req_valid_i & enable_i} >> rr_ptr;
    if (state == LOCKED) begin
      sel_vld = 1'b1;
      sel_idx = lock_idx;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        if (!sel_vld && cand2[k]) begin
          sel_vld = 1'b1;
          sum     = {1'b0, rr_ptr} + (IdxW+1)'(k);
          if (sum >= (IdxW+1)'(NumReq)) sum = sum - (IdxW+1)'(NumReq);
          sel_idx = sum[IdxW-1:0];
        end
      end
    end
  end

  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    out_idx_o   = sel_idx;
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (sel_vld && sel_idx == IdxW'(i)) begin
        out_valid_o    = req_valid_i[i];
        out_data_o     = req_data_i[i*DataWidth +: DataWidth];
        out_last_o     = req_last_i[i];
        req_ready_o[i] = out_ready_i;
      end
    end
  end

  assign hs     = out_valid_o & out_ready_i;
  assign busy_o = (state == LOCKED);
  assign err_o  = err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      lock_idx <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (hs && !out_last_o && beat_cnt == CntW'(MaxBurstBeats - 1)) err <= 1'b1;
      if (hs && out_last_o) begin
        state    <= IDLE;
        rr_ptr   <= wrap_inc(sel_idx);
        beat_cnt <= '0;
      end else if (sel_vld) begin
        // A stalled first beat also locks, so the offered beat cannot be swapped.
        state    <= LOCKED;
        lock_idx <= sel_idx;
        if (hs && beat_cnt != CntW'(MaxBurstBeats)) beat_cnt <= beat_cnt + CntW'(1);
      end
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_valid_o && !out_ready_i |=> $stable({out_valid_o, out_data_o, out_last_o, out_idx_o}));
`endif

endmodule

// File: tb/tb_tile_burst_rr_arbiter.sv
// Bench for tile_burst_rr_arbiter: directed plan steps then random traffic against a queue model.
module tb_tile_burst_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid, req_ready, req_last, enable;
  logic [N*DW-1:0] req_data;
  logic          out_valid, out_ready, out_last, busy, err;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;

  always #5 clk = ~clk;

  tile_burst_rr_arbiter #(.NumReq(N), .DataWidth(DW), .MaxBurstBeats(MB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .req_last_i(req_last), .enable_i(enable),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .out_idx_o(out_idx), .busy_o(busy), .err_o(err)
  );

  logic [DW:0] src_q [N][$];
  int          dut_log[$];
  int          checks = 0;
  int          passed = 0;
  int          m_own = -1;
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_err = 1'b0;
  logic [N-1:0] pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    logic [DW:0] b;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = b[DW-1:0];
        req_last[i]           = b[DW];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic push_burst(input int r, input int len);
    logic [DW-1:0] d;
    for (int b = 0; b < len; b++) begin
      d = DW'($urandom);
      src_q[r].push_back({(b == len - 1), d});
    end
  endtask

  // Reference: owner is -1 when free; a free channel picks the first enabled valid from m_ptr.
  task automatic model_step();
    int g;
    int c;
    bit ev;
    logic [N-1:0] one;
    logic [N-1:0] er;
    one = 1;
    g = -1;
    if (m_own >= 0) g = m_own;
    else for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (g < 0 && req_valid[c] && enable[c]) g = c;
    end
    ev = (g >= 0) ? req_valid[g] : 1'b0;
    er = (g >= 0 && out_ready) ? (one << g) : '0;
    chk("out_valid", out_valid, ev);
    chk("out_idx", out_idx, (g >= 0) ? g : m_ptr);
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_own >= 0);
    chk("err", err, m_err);
    if (ev) begin
      chk("out_data", out_data, req_data[g*DW +: DW]);
      chk("out_last", out_last, req_last[g]);
    end
    if (out_valid && out_ready) dut_log.push_back(int'(out_idx));
    if (ev && out_ready) begin
      if (req_last[g]) begin
        m_own = -1;
        m_ptr = (g + 1) % N;
        m_cnt = 0;
      end else begin
        m_own = g;
        if (m_cnt == MB - 1) m_err = 1'b1;
        m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
      end
    end else if (g >= 0) begin
      m_own = g;
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    model_step();
    pop = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (pop[i]) void'(src_q[i].pop_front());
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    m_own = -1; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string tag, input int exp[$]);
    chk({tag, "_count"}, dut_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
      chk({tag, "_idx"}, dut_log[i], exp[i]);
    dut_log.delete();
  endtask

  initial begin
    int total;
    req_valid = '0; req_last = '0; req_data = '0;
    enable = '1; out_ready = 1'b0;
    do_reset();

    // 1: all requesters, single-beat bursts, order 0,1,2,0,1,2
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin push_burst(r, 1); push_burst(r, 1); end
    repeat (6) tick();
    chk_log("t1", '{0, 1, 2, 0, 1, 2});

    // 2: req0 4-beat burst, req1 shows up at beat 2
    push_burst(0, 4);
    tick();
    push_burst(1, 1);
    repeat (5) tick();
    chk_log("t2", '{0, 0, 0, 0, 1});

    // 3: req2 stalled 5 cycles, req0 arrives at cycle 2
    out_ready = 1'b0;
    push_burst(2, 2);
    tick(); tick();
    push_burst(0, 1);
    repeat (3) tick();
    chk("t3_busy", busy, 1'b1);
    out_ready = 1'b1;
    repeat (4) tick();
    chk_log("t3", '{2, 2, 0});

    // 4: req1 masked; clearing enable[0] mid-burst keeps the burst
    enable = 3'b101;
    for (int r = 0; r < N; r++) begin push_burst(r, 1); push_burst(r, 1); end
    repeat (6) tick();
    push_burst(0, 3);
    tick();
    enable = 3'b100;
    repeat (3) tick();
    chk_log("t4", '{2, 0, 2, 0, 0, 0, 0});
    enable = '1;
    repeat (3) tick();
    chk_log("t4b", '{1, 1});

    // 5: 6-beat burst overruns the 4-beat watchdog
    push_burst(0, 6);
    repeat (8) tick();
    chk("t5_err", err, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk_log("t5", '{0, 0, 0, 0, 0, 0});

    // 6: reset while locked with three beats taken
    push_burst(0, 6);
    repeat (3) tick();
    chk("t6_busy", busy, 1'b1);
    do_reset();
    dut_log.delete();
    push_burst(2, 1);
    push_burst(1, 1);
    repeat (3) tick();
    chk_log("t6", '{1, 2});

    // Random traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int r = 0; r < N; r++)
        if (src_q[r].size() == 0 && $urandom_range(0, 5) == 0) push_burst(r, $urandom_range(1, 5));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) enable = N'($urandom);
      tick();
    end
    enable = '1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      total = 0;
      for (int r = 0; r < N; r++) total += src_q[r].size();
      if (total != 0) tick();
    end
    total = 0;
    for (int r = 0; r < N; r++) total += src_q[r].size();
    chk("drain_empty", total, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
